// File: rtl/smol_fetch_ctrl.sv
// smolCore instruction-fetch sequencer: owns the PC, issues one imem request at a time, hands words to decode.
// Optional misaligned-redirect fault checking is compiled in with SMOL_FETCH_MISALIGN_CHK_EN.
module smol_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        busy,
  output logic        fetch_fault
);

  typedef enum logic [2:0] {
    ST_REQ  = 3'd0,
    ST_WAIT = 3'd1,
    ST_KILL = 3'd2,
    ST_HOLD = 3'd3
`ifdef SMOL_FETCH_MISALIGN_CHK_EN
    , ST_FAULT = 3'd4
`endif
  } state_t;

  // ST_ERR aliases REQ when the check is compiled out; those paths are then unreachable.
`ifdef SMOL_FETCH_MISALIGN_CHK_EN
  localparam state_t ST_ERR = ST_FAULT;
`else
  localparam state_t ST_ERR = ST_REQ;
`endif

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] pc_r;
  logic [31:0] pc_nxt_s;
  logic [31:0] addr_r;
  logic        pend_r;
  logic        pend_nxt_s;
  logic        fpend_r;
  logic        fpend_nxt_s;
  logic        cap_s;
  logic        if_valid_r;
  logic [31:0] if_instr_r;
  logic [31:0] if_pc_r;
  logic        redir_ok_s;
  logic        redir_bad_s;
  logic        req_valid_s;
  logic        busy_s;

`ifdef SMOL_FETCH_MISALIGN_CHK_EN
  assign redir_bad_s = redirect_valid & (redirect_pc[1:0] != 2'b00);
  assign redir_ok_s  = redirect_valid & (redirect_pc[1:0] == 2'b00);
`else
  assign redir_bad_s = 1'b0;
  assign redir_ok_s  = redirect_valid;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_REQ;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and next-PC selection; redirect always beats the sequential +4.
  always_comb begin
    state_nxt_s = state_r;
    pend_nxt_s  = pend_r;
    fpend_nxt_s = fpend_r;
    cap_s       = 1'b0;
    if (redir_ok_s) begin
      pc_nxt_s = redirect_pc;
    end else begin
      pc_nxt_s = pc_r;
    end
    case (state_r)
      ST_REQ: begin
        if (imem_req_ready) begin
          pend_nxt_s = 1'b0;
          if (redirect_valid || pend_r) begin
            state_nxt_s = ST_KILL;
            fpend_nxt_s = redir_bad_s;
          end else begin
            state_nxt_s = ST_WAIT;
            fpend_nxt_s = 1'b0;
          end
        end else if (redir_bad_s) begin
          state_nxt_s = ST_ERR;
          pend_nxt_s  = 1'b0;
        end else if (redir_ok_s) begin
          pend_nxt_s = 1'b1;
        end else begin
          pend_nxt_s = pend_r;
        end
      end
      ST_WAIT: begin
        if (imem_resp_valid) begin
          if (redirect_valid) begin
            state_nxt_s = redir_bad_s ? ST_ERR : ST_REQ;
          end else begin
            cap_s       = 1'b1;
            state_nxt_s = ST_HOLD;
          end
        end else if (redirect_valid) begin
          state_nxt_s = ST_KILL;
          fpend_nxt_s = redir_bad_s;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_KILL: begin
        if (imem_resp_valid) begin
          state_nxt_s = (fpend_r || redir_bad_s) ? ST_ERR : ST_REQ;
          fpend_nxt_s = 1'b0;
        end else begin
          fpend_nxt_s = fpend_r | redir_bad_s;
        end
      end
      ST_HOLD: begin
        if (redir_bad_s) begin
          state_nxt_s = ST_ERR;
        end else if (redir_ok_s) begin
          state_nxt_s = ST_REQ;
        end else if (!stall) begin
          state_nxt_s = ST_REQ;
          pc_nxt_s    = if_pc_r + 32'd4;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
`ifdef SMOL_FETCH_MISALIGN_CHK_EN
      ST_FAULT: begin
        state_nxt_s = ST_FAULT;
      end
`endif
      default: begin
        state_nxt_s = ST_REQ;
      end
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    req_valid_s = 1'b0;
    busy_s      = 1'b0;
    if ((state_r == ST_REQ) && !rst) begin
      req_valid_s = 1'b1;
    end else begin
      req_valid_s = 1'b0;
    end
    if ((state_r == ST_WAIT) || (state_r == ST_KILL)) begin
      busy_s = 1'b1;
    end else begin
      busy_s = 1'b0;
    end
  end

  // PC, request address and decode-side registers; addr_r latches only on entry to REQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r       <= RESET_PC;
      addr_r     <= RESET_PC;
      pend_r     <= 1'b0;
      fpend_r    <= 1'b0;
      if_valid_r <= 1'b0;
      if_instr_r <= 32'h0000_0000;
      if_pc_r    <= 32'h0000_0000;
    end else begin
      pc_r    <= pc_nxt_s;
      pend_r  <= pend_nxt_s;
      fpend_r <= fpend_nxt_s;
      if ((state_nxt_s == ST_REQ) && (state_r != ST_REQ)) begin
        addr_r <= pc_nxt_s;
      end else begin
        addr_r <= addr_r;
      end
      if (cap_s) begin
        if_valid_r <= 1'b1;
        if_instr_r <= imem_resp_data;
        if_pc_r    <= addr_r;
      end else if ((state_r == ST_HOLD) && (state_nxt_s != ST_HOLD)) begin
        if_valid_r <= 1'b0;
      end else begin
        if_valid_r <= if_valid_r;
      end
    end
  end

`ifdef SMOL_FETCH_MISALIGN_CHK_EN
  logic fault_r;

  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_r <= 1'b0;
    end else if (state_nxt_s == ST_FAULT) begin
      fault_r <= 1'b1;
    end else begin
      fault_r <= fault_r;
    end
  end
  assign fetch_fault = fault_r;
`else
  assign fetch_fault = 1'b0;
`endif

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = addr_r;
  assign busy           = busy_s;
  assign if_valid       = if_valid_r;
  assign if_instr       = if_instr_r;
  assign if_pc          = if_pc_r;

endmodule

// File: tb/tb_smol_fetch_ctrl.sv
// Table-driven bench for smol_fetch_ctrl: one row per cycle of inputs and expected outputs.
module tb_smol_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        busy;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;

  smol_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .busy(busy), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        redv;
    logic [31:0] redpc;
    logic        stall;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ifv;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_busy;
    logic        e_fault;
  } vec_t;

  localparam logic [31:0] I0 = 32'h0000_0013;
  localparam logic [31:0] I1 = 32'h0010_0093;
  localparam logic [31:0] I2 = 32'h0020_0113;
  localparam logic [31:0] I3 = 32'h0050_0093;
  localparam logic [31:0] I5 = 32'h0000_0073;
  localparam logic [31:0] I6 = 32'h1111_1111;
  localparam logic [31:0] I7 = 32'h2222_2222;
  localparam logic [31:0] I8 = 32'h3333_3333;
  localparam logic [31:0] JK = 32'hDEAD_BEEF;
  localparam logic [31:0] FC = 32'hFFFF_FFFC;

  vec_t tbl[$];

  function automatic vec_t mk(logic rs, logic rdy, logic rv, logic [31:0] rd, logic redv,
                              logic [31:0] rpc, logic st, logic er, logic [31:0] ea, logic ev,
                              logic [31:0] ei, logic [31:0] ep, logic eb, logic ef);
    vec_t v;
    v.rst = rs; v.rdy = rdy; v.rv = rv; v.rdata = rd; v.redv = redv; v.redpc = rpc; v.stall = st;
    v.e_req = er; v.e_addr = ea; v.e_ifv = ev; v.e_instr = ei; v.e_pc = ep; v.e_busy = eb; v.e_fault = ef;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drive a row at the falling edge, then check the outputs the previous rising edge produced.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    rst = v.rst; imem_req_ready = v.rdy; imem_resp_valid = v.rv; imem_resp_data = v.rdata;
    redirect_valid = v.redv; redirect_pc = v.redpc; stall = v.stall;
    #1;
    chk({tag, ".req_valid"}, {31'd0, imem_req_valid}, {31'd0, v.e_req});
    chk({tag, ".req_addr"},  imem_req_addr, v.e_addr);
    chk({tag, ".if_valid"},  {31'd0, if_valid}, {31'd0, v.e_ifv});
    chk({tag, ".if_instr"},  if_instr, v.e_instr);
    chk({tag, ".if_pc"},     if_pc, v.e_pc);
    chk({tag, ".busy"},      {31'd0, busy}, {31'd0, v.e_busy});
    chk({tag, ".fault"},     {31'd0, fetch_fault}, {31'd0, v.e_fault});
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
    redirect_valid = 1'b0; redirect_pc = 32'd0; stall = 1'b0;

    //                rst  rdy  rv   rdata redv redpc         stall  req  addr          ifv  instr pc            busy flt
    // zero-wait streaming from reset: 0x0, 0x4, 0x8
    tbl.push_back(mk(1'b1,1'b0,1'b0,32'd0,1'b0,32'd0,        1'b0, 1'b0,32'h0,       1'b0,32'd0,32'h0,       1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,32'd0,1'b0,32'd0,        1'b0, 1'b1,32'h0,       1'b0,32'd0,32'h0,       1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,I0,   1'b0,32'd0,        1'b0, 1'b0,32'h0,       1'b0,32'd0,32'h0,       1'b1,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,32'd0,1'b0,32'd0,        1'b0, 1'b0,32'h0,       1'b1,I0,   32'h0,       1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,32'd0,1'b0,32'd0,        1'b0, 1'b1,32'h4,       1'b0,I0,   32'h0,       1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,I1,   1'b0,32'd0,        1'b0, 1'b0,32'h4,       1'b0,I0,   32'h0,       1'b1,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,32'd0,1'b0,32'd0,        1'b0, 1'b0,32'h4,       1'b1,I1,   32'h4,       1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,32'd0,1'b0,32'd0,        1'b0, 1'b1,32'h8,       1'b0,I1,   32'h4,       1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,I2,   1'b0,32'd0,        1'b0, 1'b0,32'h8,       1'b0,I1,   32'h4,       1'b1,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,32'd0,1'b0,32'd0,        1'b0, 1'b0,32'h8,       1'b1,I2,   32'h8,       1'b0,1'b0));
    // ready low 4 cycles, redirect 0x100 in the second: address holds, response killed
    tbl.push_back(mk(1'b0,1'b0,1'b0,32'd0,1'b0,32'd0,        1'b0, 1'b1,32'hC,       1'b0,I2,   32'h8,       1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,32'd0,1'b1,32'h100,      1'b0, 1'b1,32'hC,       1'b0,I2,   32'h8,       1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,32'd0,1'b0,32'd0,        1'b0, 1'b1,32'hC,       1'b0,I2,   32'h8,       1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,32'd0,1'b0,32'd0,        1'b0, 1'b1,32'hC,       1'b0,I2,   32'h8,       1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,32'd0,1'b0,32'd0,        1'b0, 1'b1,32'hC,       1'b0,I2,   32'h8,       1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,JK,   1'b0,32'd0,        1'b0, 1'b0,32'hC,       1'b0,I2,   32'h8,       1'b1,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,32'd0,1'b0,32'd0,        1'b0, 1'b1,32'h100,     1'b0,I2,   32'h8,       1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,I3,   1'b0,32'd0,        1'b0, 1'b0,32'h100,     1'b0,I2,   32'h8,       1'b1,1'b0));
    // stall 5 cycles in HOLD, then consume
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1'b0,1'b0,1'b0,32'd0,1'b0,32'd0,      1'b1, 1'b0,32'h100,     1'b1,I3,   32'h100,     1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,32'd0,1'b0,32'd0,        1'b0, 1'b0,32'h100,     1'b1,I3,   32'h100,     1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,32'd0,1'b0,32'd0,        1'b0, 1'b1,32'h104,     1'b0,I3,   32'h100,     1'b0,1'b0));
    // redirect 0x200 in WAIT, stale response 2 cycles later
    tbl.push_back(mk(1'b0,1'b0,1'b0,32'd0,1'b1,32'h200,      1'b0, 1'b0,32'h104,     1'b0,I3,   32'h100,     1'b1,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,32'd0,1'b0,32'd0,        1'b0, 1'b0,32'h104,     1'b0,I3,   32'h100,     1'b1,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,JK,   1'b0,32'd0,        1'b0, 1'b0,32'h104,     1'b0,I3,   32'h100,     1'b1,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,32'd0,1'b0,32'd0,        1'b0, 1'b1,32'h200,     1'b0,I3,   32'h100,     1'b0,1'b0));
    // redirect coincident with response: data dropped, straight to REQ
    tbl.push_back(mk(1'b0,1'b0,1'b1,JK,   1'b1,32'h300,      1'b0, 1'b0,32'h200,     1'b0,I3,   32'h100,     1'b1,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,32'd0,1'b0,32'd0,        1'b0, 1'b1,32'h300,     1'b0,I3,   32'h100,     1'b0,1'b0));
    // fetch at 0xFFFF_FFFC wraps to 0
    tbl.push_back(mk(1'b0,1'b0,1'b1,JK,   1'b1,FC,           1'b0, 1'b0,32'h300,     1'b0,I3,   32'h100,     1'b1,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,32'd0,1'b0,32'd0,        1'b0, 1'b1,FC,          1'b0,I3,   32'h100,     1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,I5,   1'b0,32'd0,        1'b0, 1'b0,FC,          1'b0,I3,   32'h100,     1'b1,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,32'd0,1'b0,32'd0,        1'b0, 1'b0,FC,          1'b1,I5,   FC,          1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,32'd0,1'b0,32'd0,        1'b0, 1'b1,32'h0,       1'b0,I5,   FC,          1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,I6,   1'b0,32'd0,        1'b0, 1'b0,32'h0,       1'b0,I5,   FC,          1'b1,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,32'd0,1'b0,32'd0,        1'b0, 1'b0,32'h0,       1'b1,I6,   32'h0,       1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,32'd0,1'b0,32'd0,        1'b0, 1'b1,32'h4,       1'b0,I6,   32'h0,       1'b0,1'b0));
    // reset during WAIT, then first request at RESET_PC
    tbl.push_back(mk(1'b1,1'b0,1'b0,32'd0,1'b0,32'd0,        1'b0, 1'b0,32'h4,       1'b0,I6,   32'h0,       1'b1,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,32'd0,1'b0,32'd0,        1'b0, 1'b0,32'h0,       1'b0,32'd0,32'h0,       1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,32'd0,1'b0,32'd0,        1'b0, 1'b1,32'h0,       1'b0,32'd0,32'h0,       1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,32'd0,1'b0,32'd0,        1'b0, 1'b1,32'h0,       1'b0,32'd0,32'h0,       1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,I7,   1'b0,32'd0,        1'b0, 1'b0,32'h0,       1'b0,32'd0,32'h0,       1'b1,1'b0));
    // redirect in HOLD while stalled; stray response in REQ ignored
    tbl.push_back(mk(1'b0,1'b0,1'b0,32'd0,1'b1,32'h400,      1'b1, 1'b0,32'h0,       1'b1,I7,   32'h0,       1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,JK,   1'b0,32'd0,        1'b0, 1'b1,32'h400,     1'b0,I7,   32'h0,       1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,32'd0,1'b0,32'd0,        1'b0, 1'b1,32'h400,     1'b0,I7,   32'h0,       1'b0,1'b0));
    // redirect in the accept cycle -> KILL, then REQ at the target
    tbl.push_back(mk(1'b0,1'b1,1'b0,32'd0,1'b1,32'h500,      1'b0, 1'b1,32'h400,     1'b0,I7,   32'h0,       1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,32'd0,1'b0,32'd0,        1'b0, 1'b0,32'h400,     1'b0,I7,   32'h0,       1'b1,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,JK,   1'b0,32'd0,        1'b0, 1'b0,32'h400,     1'b0,I7,   32'h0,       1'b1,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,32'd0,1'b0,32'd0,        1'b0, 1'b1,32'h500,     1'b0,I7,   32'h0,       1'b0,1'b0));

    repeat (2) @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("row%0d", i));

    // misaligned redirect 0x102 while an instruction sits in HOLD
    apply(mk(1'b0,1'b1,1'b0,32'd0,1'b0,32'd0,   1'b0, 1'b1,32'h500,1'b0,I7,32'h0,  1'b0,1'b0), "mis0");
    apply(mk(1'b0,1'b0,1'b1,I8,   1'b0,32'd0,   1'b0, 1'b0,32'h500,1'b0,I7,32'h0,  1'b1,1'b0), "mis1");
    apply(mk(1'b0,1'b0,1'b0,32'd0,1'b1,32'h102, 1'b0, 1'b0,32'h500,1'b1,I8,32'h500,1'b0,1'b0), "mis2");
`ifdef SMOL_FETCH_MISALIGN_CHK_EN
    for (int k = 0; k < 5; k++)
      apply(mk(1'b0,1'b1,1'b0,32'd0,1'b0,32'd0, 1'b0, 1'b0,32'h500,1'b0,I8,32'h500,1'b0,1'b1), $sformatf("flt%0d", k));
    apply(mk(1'b1,1'b0,1'b0,32'd0,1'b0,32'd0,   1'b0, 1'b0,32'h500,1'b0,I8,32'h500,1'b0,1'b1), "frst0");
    apply(mk(1'b0,1'b1,1'b0,32'd0,1'b0,32'd0,   1'b0, 1'b1,32'h0,  1'b0,32'd0,32'h0,1'b0,1'b0), "frst1");
    // misaligned redirect in WAIT: absorb the stale response in KILL, then fault
    apply(mk(1'b0,1'b0,1'b0,32'd0,1'b1,32'h202, 1'b0, 1'b0,32'h0,  1'b0,32'd0,32'h0,1'b1,1'b0), "fk0");
    apply(mk(1'b0,1'b0,1'b1,JK,   1'b0,32'd0,   1'b0, 1'b0,32'h0,  1'b0,32'd0,32'h0,1'b1,1'b0), "fk1");
    apply(mk(1'b0,1'b1,1'b0,32'd0,1'b0,32'd0,   1'b0, 1'b0,32'h0,  1'b0,32'd0,32'h0,1'b0,1'b1), "fk2");
`else
    for (int k = 0; k < 3; k++)
      apply(mk(1'b0,1'b0,1'b0,32'd0,1'b0,32'd0, 1'b0, 1'b1,32'h102,1'b0,I8,32'h500,1'b0,1'b0), $sformatf("nof%0d", k));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
